// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM for the 24-bit multicycle datapath. It steps each instruction
//   through FETCH, DECODE, EXEC, MEM and WB. It decodes the instruction
//   register, which is laid out as {op[23:20], rd[19:16], rs[15:12], imm[11:0]}.
//   It also runs the memory handshake. A wait counter bounds that handshake,
//   so a memory that never answers ends in a fault-halt rather than a hang.
//
// Parameters
//   MEM_TIMEOUT  cycles to wait for mem_ready in FETCH/MEM before fault-halt (1..255)
//   CNTW         width of the retired-instruction counter
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   instr      IR contents (valid from DECODE onward)
//   zero       ALU zero flag for the current cycle
//   mem_ready  memory completes the current read/write this cycle
//   ir_we      load IR from memory data
//   pc_we      PC write enable
//   pc_src     0=ALU(PC+1) 1=target reg 2=sext(imm)
//   iord       0=PC addresses memory, 1=ALUOut addresses memory
//   mem_rd     memory read strobe
//   mem_wr     memory write strobe
//   alu_src_a  0=PC 1=reg[rs]
//   alu_src_b  0=reg[rd] 1=sext(imm) 2=constant 1
//   alu_op     0=ADD 1=SUB
//   tgt_we     latch ALU result into the branch-target register
//   reg_we     register-file write to rd
//   wb_sel     0=ALUOut 1=memory data
//   halted     FSM is in HALT
//   fault      the halt was caused by an illegal opcode or a memory timeout
//   retired    count of completed instructions, wraps to 0
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNTW        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [23:0]     instr,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_src,
  output logic            iord,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic            alu_op,
  output logic            tgt_we,
  output logic            reg_we,
  output logic            wb_sel,
  output logic            halted,
  output logic            fault,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  state_t          state;
  state_t          state_nx;
  logic [7:0]      wait_cnt;
  logic            fault_q;
  logic [CNTW-1:0] retired_q;

  logic [3:0]      op;
  logic            waiting;
  logic            retire;
  logic            set_fault;
  logic            timed_out;
  logic            unused_fields;

  assign op = instr[23:20];

  // The register fields and the immediate are routed by the datapath itself.
  // Only the opcode matters to the controller, so the remaining bits are
  // gathered here to mark them as intentionally unused.
  assign unused_fields = ^instr[19:0];

  // In FETCH or MEM, the memory has run out of time once the wait counter
  // reaches the limit and mem_ready is still low. A mem_ready that arrives
  // in that same cycle still completes the access normally.
  assign timed_out = !mem_ready && (wait_cnt >= WAIT_LIMIT);

  // Next-state and output decode. Every control output defaults to 0, so
  // each state only has to name the strobes it raises. A timeout cycle
  // raises nothing and only steers the FSM into HALT. When reset is high,
  // the final block clears every strobe, whatever state the FSM is in.
  always_comb begin
    state_nx  = state;
    waiting   = 1'b0;
    retire    = 1'b0;
    set_fault = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    iord      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    alu_op    = 1'b0;
    tgt_we    = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;

    case (state)
      FETCH: begin
        if (timed_out) begin
          state_nx  = HALT;
          set_fault = 1'b1;
        end else begin
          iord   = 1'b0;
          mem_rd = 1'b1;
          if (mem_ready) begin
            ir_we     = 1'b1;
            pc_we     = 1'b1;
            pc_src    = 2'd0;
            alu_src_a = 1'b0;
            alu_src_b = 2'd2;
            alu_op    = 1'b0;
            state_nx  = DECODE;
          end else begin
            waiting = 1'b1;
          end
        end
      end

      DECODE: begin
        alu_src_a = 1'b0;
        alu_src_b = 2'd1;
        alu_op    = 1'b0;
        tgt_we    = 1'b1;
        case (op)
          OP_ADD, OP_SUB, OP_ADDI, OP_LD, OP_ST, OP_BEQ, OP_JMP: state_nx = EXEC;
          OP_HALT: state_nx = HALT;
          default: begin
            state_nx  = HALT;
            set_fault = 1'b1;
          end
        endcase
      end

      EXEC: begin
        case (op)
          OP_ADD, OP_SUB: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd0;
            alu_op    = op[0];
            state_nx  = WB;
          end
          OP_ADDI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd1;
            alu_op    = 1'b0;
            state_nx  = WB;
          end
          OP_LD, OP_ST: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd1;
            alu_op    = 1'b0;
            state_nx  = MEM;
          end
          OP_BEQ: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd0;
            alu_op    = 1'b1;
            pc_src    = 2'd1;
            pc_we     = zero;
            retire    = 1'b1;
            state_nx  = FETCH;
          end
          OP_JMP: begin
            pc_we    = 1'b1;
            pc_src   = 2'd2;
            retire   = 1'b1;
            state_nx = FETCH;
          end
          default: begin
            state_nx  = HALT;
            set_fault = 1'b1;
          end
        endcase
      end

      MEM: begin
        if (timed_out) begin
          state_nx  = HALT;
          set_fault = 1'b1;
        end else begin
          iord   = 1'b1;
          mem_rd = (op == OP_LD);
          mem_wr = (op == OP_ST);
          if (mem_ready) begin
            if (op == OP_LD) begin
              state_nx = WB;
            end else begin
              retire   = 1'b1;
              state_nx = FETCH;
            end
          end else begin
            waiting = 1'b1;
          end
        end
      end

      WB: begin
        reg_we   = 1'b1;
        wb_sel   = (op == OP_LD);
        retire   = 1'b1;
        state_nx = FETCH;
      end

      HALT: begin
        state_nx = HALT;
      end

      default: begin
        state_nx  = HALT;
        set_fault = 1'b1;
      end
    endcase

    if (reset) begin
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'd0;
      iord      = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'd0;
      alu_op    = 1'b0;
      tgt_we    = 1'b0;
      reg_we    = 1'b0;
      wb_sel    = 1'b0;
    end
  end

  // State register. Reset sends the FSM back to FETCH, which abandons any
  // instruction that was in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_nx;
    end
  end

  // The wait counter measures how long the FSM has been stalled in one
  // state. Any state change clears it, so every memory access gets its own
  // full timeout window.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (state_nx != state) begin
      wait_cnt <= 8'd0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Status registers. The fault flag is sticky until reset. The retired
  // counter steps on the edge that leaves an instruction's final state and
  // wraps naturally at its width. A reset in the middle of an instruction
  // clears the counter and never credits the abandoned instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      if (set_fault) begin
        fault_q <= 1'b1;
      end
      if (retire) begin
        retired_q <= retired_q + CNTW'(1);
      end
    end
  end

  assign halted  = (state == HALT);
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl, built with MEM_TIMEOUT=4. A table of
//   per-cycle vectors walks every opcode through the FSM. The vectors cover
//   memory wait states, a fetch that completes exactly at the timeout limit,
//   and a reset in the middle of a store. Hand-written sequences then cover
//   a timeout in FETCH and in MEM, the illegal-opcode halt, the HALT opcode,
//   and recovery through reset.
//   Each vector's inputs are applied just after a rising edge. The outputs
//   are sampled on the following falling edge. The FSM consumes those
//   inputs on the rising edge after that.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int CNTW = 16;

  // Control outputs packed as
  // {ir_we, pc_we, pc_src[1:0], iord, mem_rd, mem_wr, alu_src_a,
  //  alu_src_b[1:0], alu_op, tgt_we, reg_we, wb_sel}
  localparam logic [13:0] C_NONE      = 14'd0;
  localparam logic [13:0] C_FWAIT     = {1'b0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [13:0] C_FGO       = {1'b1,1'b1,2'd0,1'b0,1'b1,1'b0,1'b0,2'd2,1'b0,1'b0,1'b0,1'b0};
  localparam logic [13:0] C_DEC       = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,1'b1,1'b0,1'b0};
  localparam logic [13:0] C_EX_ADD    = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [13:0] C_EX_SUB    = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b1,1'b0,1'b0,1'b0};
  localparam logic [13:0] C_EX_IMM    = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0};
  localparam logic [13:0] C_EX_BEQ_T  = {1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b1,2'd0,1'b1,1'b0,1'b0,1'b0};
  localparam logic [13:0] C_EX_BEQ_N  = {1'b0,1'b0,2'd1,1'b0,1'b0,1'b0,1'b1,2'd0,1'b1,1'b0,1'b0,1'b0};
  localparam logic [13:0] C_EX_JMP    = {1'b0,1'b1,2'd2,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [13:0] C_MEM_LD    = {1'b0,1'b0,2'd0,1'b1,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [13:0] C_MEM_ST    = {1'b0,1'b0,2'd0,1'b1,1'b0,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [13:0] C_WB_ALU    = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [13:0] C_WB_LD     = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b1,1'b1};

  localparam logic [23:0] I_ADDI = 24'h21200F;
  localparam logic [23:0] I_LD   = 24'h321E0C;
  localparam logic [23:0] I_BEQ  = 24'h534010;
  localparam logic [23:0] I_ADD  = 24'h012000;
  localparam logic [23:0] I_SUB  = 24'h112000;
  localparam logic [23:0] I_JMP  = 24'h600ABC;
  localparam logic [23:0] I_ST   = 24'h412005;
  localparam logic [23:0] I_BAD  = 24'hA12345;
  localparam logic [23:0] I_HALT = 24'hF00000;

  typedef struct {
    logic            rst;
    logic [23:0]     ins;
    logic            zf;
    logic            rdy;
    logic [13:0]     exp_ctl;
    logic            exp_halted;
    logic            exp_fault;
    logic [CNTW-1:0] exp_retired;
  } vec_t;

  logic            clk;
  logic            reset;
  logic [23:0]     instr;
  logic            zero;
  logic            mem_ready;
  logic            ir_we;
  logic            pc_we;
  logic [1:0]      pc_src;
  logic            iord;
  logic            mem_rd;
  logic            mem_wr;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic            alu_op;
  logic            tgt_we;
  logic            reg_we;
  logic            wb_sel;
  logic            halted;
  logic            fault;
  logic [CNTW-1:0] retired;
  logic [13:0]     dut_ctl;

  int n_compared;
  int n_mismatched;
  vec_t vecs[$];

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .iord      (iord),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .tgt_we    (tgt_we),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired)
  );

  assign dut_ctl = {ir_we, pc_we, pc_src, iord, mem_rd, mem_wr, alu_src_a,
                    alu_src_b, alu_op, tgt_we, reg_we, wb_sel};

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Appends one cycle to the vector table.
  task automatic addVec(input logic r, input logic [23:0] i, input logic z, input logic m,
                        input logic [13:0] c, input logic h, input logic f,
                        input logic [CNTW-1:0] n);
    vecs.push_back('{rst: r, ins: i, zf: z, rdy: m, exp_ctl: c,
                     exp_halted: h, exp_fault: f, exp_retired: n});
  endtask

  // Drives one cycle's inputs just after the rising edge.
  task automatic applyStimulus(input logic r, input logic [23:0] i, input logic z, input logic m);
    @(posedge clk);
    #1;
    reset     = r;
    instr     = i;
    zero      = z;
    mem_ready = m;
  endtask

  // Samples the outputs on the falling edge and checks them against expectations.
  task automatic checkOutput(input string tag, input logic [13:0] c, input logic h,
                             input logic f, input logic [CNTW-1:0] n);
    @(negedge clk);
    n_compared++;
    if (dut_ctl !== c) begin
      n_mismatched++;
      $display("[TB] FAIL %s ctl: got %b expected %b", tag, dut_ctl, c);
    end
    n_compared++;
    if (halted !== h) begin
      n_mismatched++;
      $display("[TB] FAIL %s halted: got %b expected %b", tag, halted, h);
    end
    n_compared++;
    if (fault !== f) begin
      n_mismatched++;
      $display("[TB] FAIL %s fault: got %b expected %b", tag, fault, f);
    end
    n_compared++;
    if (retired !== n) begin
      n_mismatched++;
      $display("[TB] FAIL %s retired: got %0d expected %0d", tag, retired, n);
    end
  endtask

  // Shorthand for one cycle with reset low: drive, then check.
  task automatic step(input string tag, input logic [23:0] i, input logic z, input logic m,
                      input logic [13:0] c, input logic h, input logic f,
                      input logic [CNTW-1:0] n);
    applyStimulus(1'b0, i, z, m);
    checkOutput(tag, c, h, f, n);
  endtask

  // Main sequence: the table first, then the hand-written corner cases.
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b1;
    instr        = 24'd0;
    zero         = 1'b0;
    mem_ready    = 1'b0;
    repeat (2) @(posedge clk);

    addVec(1, I_ADDI, 0, 1, C_NONE, 0, 0, 0);
    addVec(0, I_ADDI, 0, 1, C_FGO, 0, 0, 0);
    addVec(0, I_ADDI, 0, 1, C_DEC, 0, 0, 0);
    addVec(0, I_ADDI, 0, 1, C_EX_IMM, 0, 0, 0);
    addVec(0, I_ADDI, 0, 1, C_WB_ALU, 0, 0, 0);
    addVec(0, I_LD, 0, 1, C_FGO, 0, 0, 1);
    addVec(0, I_LD, 0, 1, C_DEC, 0, 0, 1);
    addVec(0, I_LD, 0, 1, C_EX_IMM, 0, 0, 1);
    for (int k = 0; k < 3; k++) addVec(0, I_LD, 0, 0, C_MEM_LD, 0, 0, 1);
    addVec(0, I_LD, 0, 1, C_MEM_LD, 0, 0, 1);
    addVec(0, I_LD, 0, 1, C_WB_LD, 0, 0, 1);
    addVec(0, I_BEQ, 0, 1, C_FGO, 0, 0, 2);
    addVec(0, I_BEQ, 0, 1, C_DEC, 0, 0, 2);
    addVec(0, I_BEQ, 1, 1, C_EX_BEQ_T, 0, 0, 2);
    addVec(0, I_BEQ, 0, 1, C_FGO, 0, 0, 3);
    addVec(0, I_BEQ, 0, 1, C_DEC, 0, 0, 3);
    addVec(0, I_BEQ, 0, 1, C_EX_BEQ_N, 0, 0, 3);
    addVec(0, I_ADD, 0, 1, C_FGO, 0, 0, 4);
    addVec(0, I_ADD, 0, 1, C_DEC, 0, 0, 4);
    addVec(0, I_ADD, 0, 1, C_EX_ADD, 0, 0, 4);
    addVec(0, I_ADD, 0, 1, C_WB_ALU, 0, 0, 4);
    addVec(0, I_SUB, 0, 1, C_FGO, 0, 0, 5);
    addVec(0, I_SUB, 0, 1, C_DEC, 0, 0, 5);
    addVec(0, I_SUB, 0, 1, C_EX_SUB, 0, 0, 5);
    addVec(0, I_SUB, 0, 1, C_WB_ALU, 0, 0, 5);
    for (int k = 0; k < 4; k++) addVec(0, I_JMP, 0, 0, C_FWAIT, 0, 0, 6);
    addVec(0, I_JMP, 0, 1, C_FGO, 0, 0, 6);
    addVec(0, I_JMP, 0, 1, C_DEC, 0, 0, 6);
    addVec(0, I_JMP, 0, 1, C_EX_JMP, 0, 0, 6);
    addVec(0, I_ST, 0, 0, C_FWAIT, 0, 0, 7);
    addVec(0, I_ST, 0, 1, C_FGO, 0, 0, 7);
    addVec(0, I_ST, 0, 1, C_DEC, 0, 0, 7);
    addVec(0, I_ST, 0, 1, C_EX_IMM, 0, 0, 7);
    addVec(0, I_ST, 0, 1, C_MEM_ST, 0, 0, 7);
    addVec(0, I_ST, 0, 1, C_FGO, 0, 0, 8);
    addVec(0, I_ST, 0, 1, C_DEC, 0, 0, 8);
    addVec(0, I_ST, 0, 1, C_EX_IMM, 0, 0, 8);
    addVec(0, I_ST, 0, 0, C_MEM_ST, 0, 0, 8);
    addVec(1, I_ST, 0, 1, C_NONE, 0, 0, 8);
    addVec(0, I_ST, 0, 0, C_FWAIT, 0, 0, 0);

    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v].rst, vecs[v].ins, vecs[v].zf, vecs[v].rdy);
      checkOutput($sformatf("vec%0d", v), vecs[v].exp_ctl, vecs[v].exp_halted,
                  vecs[v].exp_fault, vecs[v].exp_retired);
    end

    // Fetch timeout: four stalled reads, one silent cycle, then a faulted HALT.
    applyStimulus(1'b1, I_ADD, 1'b0, 1'b0);
    checkOutput("fto_reset", C_NONE, 0, 0, 0);
    for (int k = 0; k < 4; k++) step($sformatf("fto_wait%0d", k), I_ADD, 0, 0, C_FWAIT, 0, 0, 0);
    step("fto_limit", I_ADD, 0, 0, C_NONE, 0, 0, 0);
    for (int k = 0; k < 3; k++) step($sformatf("fto_halt%0d", k), I_ADD, 0, 1, C_NONE, 1, 1, 0);

    // Memory timeout during a load.
    applyStimulus(1'b1, I_LD, 1'b0, 1'b1);
    checkOutput("mto_reset", C_NONE, 1, 1, 0);
    step("mto_fetch", I_LD, 0, 1, C_FGO, 0, 0, 0);
    step("mto_dec", I_LD, 0, 1, C_DEC, 0, 0, 0);
    step("mto_exec", I_LD, 0, 1, C_EX_IMM, 0, 0, 0);
    for (int k = 0; k < 4; k++) step($sformatf("mto_wait%0d", k), I_LD, 0, 0, C_MEM_LD, 0, 0, 0);
    step("mto_limit", I_LD, 0, 0, C_NONE, 0, 0, 0);
    for (int k = 0; k < 2; k++) step($sformatf("mto_halt%0d", k), I_LD, 0, 1, C_NONE, 1, 1, 0);

    // An illegal opcode halts with fault set.
    applyStimulus(1'b1, I_BAD, 1'b0, 1'b1);
    checkOutput("ill_reset", C_NONE, 1, 1, 0);
    step("ill_fetch", I_BAD, 0, 1, C_FGO, 0, 0, 0);
    step("ill_dec", I_BAD, 0, 1, C_DEC, 0, 0, 0);
    for (int k = 0; k < 2; k++) step($sformatf("ill_halt%0d", k), I_BAD, 0, 1, C_NONE, 1, 1, 0);

    // A HALT opcode halts cleanly, and retired holds while halted.
    applyStimulus(1'b1, I_ADDI, 1'b0, 1'b1);
    checkOutput("hlt_reset", C_NONE, 1, 1, 0);
    step("hlt_addi_f", I_ADDI, 0, 1, C_FGO, 0, 0, 0);
    step("hlt_addi_d", I_ADDI, 0, 1, C_DEC, 0, 0, 0);
    step("hlt_addi_e", I_ADDI, 0, 1, C_EX_IMM, 0, 0, 0);
    step("hlt_addi_w", I_ADDI, 0, 1, C_WB_ALU, 0, 0, 0);
    step("hlt_fetch", I_HALT, 0, 1, C_FGO, 0, 0, 1);
    step("hlt_dec", I_HALT, 0, 1, C_DEC, 0, 0, 1);
    for (int k = 0; k < 2; k++) step($sformatf("hlt_halt%0d", k), I_HALT, 0, 1, C_NONE, 1, 0, 1);
    applyStimulus(1'b1, I_ADD, 1'b0, 1'b1);
    checkOutput("hlt_exit_reset", C_NONE, 1, 0, 1);
    step("hlt_after", I_ADD, 0, 0, C_FWAIT, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
